color_layer_arbiter: RTL and testbench
======================================

// Module: color_layer_arbiter
// PURPOSE
//   Per-pixel arbiter between sprite/tile renderers (player, bombs, blasts, walls)
//   that share the single palette lookup feeding the VGA colour path. Each cycle it
//   picks one opaque layer by fixed priority and forwards its colour index plus DrawX,
//   pipelined and aligned. Also runs the frame-based blink schedule (invulnerable
//   player, fusing bombs). Sits between the renderers and the colour table.
// PARAMETERS
//   N_LAYERS      4   requester count; layer 0 = highest priority (2..8)
//   IDX_W         4   colour-index width
//   TRANSP_IDX    0   index meaning "transparent" (falls through to lower layers)
//   BLINK_FRAMES  8   frames per blink half-period (>=1)
// PORTS
//   Clk           in   1              pixel clock
//   Reset_n       in   1              synchronous reset, active low
//   frame_start   in   1              1-cycle pulse at start of vertical blank
//   pix_valid_in  in   1              DrawX_in / layer_* valid this cycle
//   DrawX_in      in   10             pixel column
//   layer_req     in   N_LAYERS       layer i covers this pixel
//   layer_idx     in   N_LAYERS*IDX_W layer i index at [i*IDX_W +: IDX_W]
//   layer_blink   in   N_LAYERS       layer i subject to blink
//   pix_valid_out out  1              outputs below valid
//   DrawX_out     out  10             DrawX_in delayed 2 cycles
//   color_out     out  IDX_W          winning index (TRANSP_IDX if none)
//   winner        out  3              winning layer number (0 if bg_hit)
//   bg_hit        out  1              no layer won; background shown
//   blink_phase   out  1              1 = blinking layers currently hidden
// BEHAVIOUR
//   - Reset (Reset_n=0 at Clk edge): all outputs 0, pipeline valids cleared,
//     frame counter 0, blink_phase 0. Reset mid-line drops in-flight pixels, no
//     partial output.
//   - Latency 2: S1 registers inputs; S2 registers arbitration result. One pixel/cycle,
//     no backpressure. pix_valid_out = pix_valid_in delayed 2.
//   - Eligible(i) = layer_req[i] & (layer_idx_i != TRANSP_IDX)
//     & !(layer_blink[i] & blink_phase). Winner = lowest eligible i.
//   - No eligible layer: color_out=TRANSP_IDX, winner=0, bg_hit=1.
//   - pix_valid_in=0: S1 valid clears; S2 outputs hold values, pix_valid_out=0.
//   - Blink FSM, states SHOW(phase 0) / HIDE(phase 1): frame_cnt increments on
//     frame_start; on frame_start with frame_cnt==BLINK_FRAMES-1, frame_cnt<=0 and
//     state toggles. New phase applies to pixels entering S1 the cycle after the
//     pulse; a pixel in S1 on the pulse cycle uses the old phase.
//   - frame_start with pix_valid_in=1 is legal; pixel processed normally.
//   - Cycle-accurate, not sampled mid-pixel. winner width fixed at 3 bits.
// CONFIGURATION
//   COLOR_ARB_COLLIDE_EN defined: adds outputs collide (1) and collide_mask
//   (N_LAYERS). Within a frame, any valid pixel where layer 0 and another layer j
//   are both eligible sets sticky collide_acc[j]. On frame_start, collide_mask <=
//   collide_acc (including same-cycle hits), collide <= |collide_acc, accumulator
//   clears. Reset clears all. Used for player-vs-blast hit detection.
//   Not defined: ports absent, no logic; arbitration identical.
// TESTING
//   1 Reset: Reset_n=0 with active inputs for 3 cycles -> all outputs 0; first
//     valid pixel after release appears exactly 2 cycles later.
//   2 Priority: req=4'b1110, idx={3,2,5,X} (layers 3..0) -> color_out=5, winner=1;
//     set layer1 idx=0 -> color_out=2, winner=2.
//   3 Background: req=0 for 640 px, DrawX 0..639 -> bg_hit=1, color_out=0,
//     DrawX_out = DrawX_in delayed 2 on every pixel.
//   4 Blink: BLINK_FRAMES=2, layer0 blink, req=4'b0011 -> winner 0 for frames 0-1,
//     1 for frames 2-3, 0 for 4-5. Phase changes on the pixel after frame_start.
//   5 Mid-frame reset: assert Reset_n=0 1 cycle during stream -> next 2 cycles
//     pix_valid_out=0; blink_phase back to 0.
//   6 (COLLIDE_EN) layer0 & layer2 eligible on 1 px in frame N -> at next
//     frame_start collide=1, mask=4'b0100; clean frame N+1 -> 0 after its end.

Source files
------------

// File: rtl/color_layer_arbiter.sv
// color_layer_arbiter
//   Chooses one opaque renderer layer per pixel for the shared palette lookup.
//   Layer 0 has the highest priority. A layer is eligible when it covers the pixel,
//   its index is not the transparent index, and it is not hidden by the blink phase.
//   The pipeline has two stages and accepts one pixel per cycle:
//     S1 registers the pixel, its column and its eligible-layer mask.
//     S2 registers the arbitration result.
//   A frame-counting FSM runs the blink schedule. It toggles between SHOW and HIDE
//   every BLINK_FRAMES frame_start pulses.
//   Optional feature, enabled by the macro COLOR_ARB_COLLIDE_EN: per-frame collision
//   reporting between layer 0 and every other layer (collide / collide_mask outputs).
module color_layer_arbiter #(
    parameter int N_LAYERS     = 4,
    parameter int IDX_W        = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_start,
    input  logic                      pix_valid_in,
    input  logic [9:0]                DrawX_in,
    input  logic [N_LAYERS-1:0]       layer_req,
    input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [N_LAYERS-1:0]       layer_blink,
    output logic                      pix_valid_out,
    output logic [9:0]                DrawX_out,
    output logic [IDX_W-1:0]          color_out,
    output logic [2:0]                winner,
    output logic                      bg_hit,
    output logic                      blink_phase
`ifdef COLOR_ARB_COLLIDE_EN
    ,
    output logic                      collide,
    output logic [N_LAYERS-1:0]       collide_mask
`endif
);

    localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);
    localparam int               CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [0:0] ST_SHOW = 1'b0;
    localparam logic [0:0] ST_HIDE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_now;

    logic [N_LAYERS-1:0] elig_d;

    logic                      s1_valid_q;
    logic [9:0]                s1_x_q;
    logic [N_LAYERS-1:0]       s1_elig_q;
    logic [N_LAYERS*IDX_W-1:0] s1_idx_q;

    logic [IDX_W-1:0] col_d;
    logic [2:0]       win_d;
    logic             bg_d;

    logic             out_valid_q;
    logic [9:0]       out_x_q;
    logic [IDX_W-1:0] out_col_q;
    logic [2:0]       out_win_q;
    logic             out_bg_q;

    assign phase_now = (state_q == ST_HIDE);

    // Eligibility is taken with the phase seen when the pixel enters S1, so a pixel
    // presented together with frame_start still uses the old phase.
    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_elig
            assign elig_d[gi] = layer_req[gi]
                              & (layer_idx[gi*IDX_W +: IDX_W] != TRANSP)
                              & ~(layer_blink[gi] & phase_now);
        end
    endgenerate

    // Blink schedule: count frames and flip the phase after BLINK_FRAMES of them.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = (state_q == ST_SHOW) ? ST_HIDE : ST_SHOW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Blink FSM state and frame counter registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // S1: capture the pixel and its eligible-layer mask.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_elig_q  <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= pix_valid_in;
            s1_x_q     <= DrawX_in;
            s1_elig_q  <= elig_d;
            s1_idx_q   <= layer_idx;
        end
    end

    // Fixed-priority select. Scanning from the top down leaves the lowest eligible
    // layer as the winner.
    always_comb begin
        win_d = 3'd0;
        col_d = TRANSP;
        bg_d  = 1'b1;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (s1_elig_q[i]) begin
                win_d = 3'(i);
                col_d = s1_idx_q[i*IDX_W +: IDX_W];
                bg_d  = 1'b0;
            end
        end
    end

    // S2: register the result. The previous values are held while no pixel is flowing.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_col_q   <= '0;
            out_win_q   <= '0;
            out_bg_q    <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_x_q   <= s1_x_q;
                out_col_q <= col_d;
                out_win_q <= win_d;
                out_bg_q  <= bg_d;
            end
        end
    end

    assign pix_valid_out = out_valid_q;
    assign DrawX_out     = out_x_q;
    assign color_out     = out_col_q;
    assign winner        = out_win_q;
    assign bg_hit        = out_bg_q;
    assign blink_phase   = phase_now;

`ifdef COLOR_ARB_COLLIDE_EN
    logic [N_LAYERS-1:0] acc_q, acc_d, hits_now;
    logic [N_LAYERS-1:0] mask_q;
    logic                collide_q;

    // Hits are layers overlapping an eligible layer 0. Bit 0 is never set.
    assign hits_now = (pix_valid_in & elig_d[0]) ?
                      (elig_d & {{(N_LAYERS-1){1'b1}}, 1'b0}) : '0;
    assign acc_d    = acc_q | hits_now;

    // Sticky per-frame accumulator. At frame_start it is published and cleared.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            acc_q     <= '0;
            mask_q    <= '0;
            collide_q <= 1'b0;
        end else if (frame_start) begin
            acc_q     <= '0;
            mask_q    <= acc_d;
            collide_q <= |acc_d;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign collide      = collide_q;
    assign collide_mask = mask_q;
`endif

endmodule

// File: tb/tb_color_layer_arbiter.sv
// Testbench for color_layer_arbiter (N_LAYERS=4, IDX_W=4, TRANSP_IDX=0, BLINK_FRAMES=2).
// A frame-count / first-eligible-layer model predicts every output on every cycle.
// Literal checks pin the model on hand-worked cases.
module tb_color_layer_arbiter;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n, fs, pv;
    logic [9:0]  dx;
    logic [3:0]  req, blk;
    logic [15:0] idx;

    logic        pv_o, bg_o, ph_o;
    logic [9:0]  dx_o;
    logic [3:0]  col_o;
    logic [2:0]  win_o;
`ifdef COLOR_ARB_COLLIDE_EN
    logic        collide_o;
    logic [3:0]  mask_o;
`endif

    color_layer_arbiter #(
        .N_LAYERS(4), .IDX_W(4), .TRANSP_IDX(0), .BLINK_FRAMES(BF)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .frame_start(fs), .pix_valid_in(pv),
        .DrawX_in(dx), .layer_req(req), .layer_idx(idx), .layer_blink(blk),
        .pix_valid_out(pv_o), .DrawX_out(dx_o), .color_out(col_o), .winner(win_o),
        .bg_hit(bg_o), .blink_phase(ph_o)
`ifdef COLOR_ARB_COLLIDE_EN
        , .collide(collide_o), .collide_mask(mask_o)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state.
    int         m_frames;
    bit         m_s1_v, m_o_v, m_s1_bg, m_o_bg;
    logic [9:0] m_s1_x, m_o_x;
    logic [3:0] m_s1_c, m_o_c;
    logic [2:0] m_s1_w, m_o_w;
    logic [3:0] m_acc, m_mask;
    bit         m_col;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit phase_of(input int frames);
        return ((frames / BF) % 2) == 1;
    endfunction

    function automatic logic [3:0] eligible(input logic [3:0] rq, input logic [15:0] ix,
                                            input logic [3:0] bk, input bit ph);
        logic [3:0] e;
        for (int i = 0; i < 4; i++)
            e[i] = rq[i] && (ix[i*4 +: 4] != 4'd0) && !(bk[i] && ph);
        return e;
    endfunction

    task automatic compare_all();
        chk("pix_valid_out", int'(pv_o), int'(m_o_v));
        chk("DrawX_out", int'(dx_o), int'(m_o_x));
        chk("color_out", int'(col_o), int'(m_o_c));
        chk("winner", int'(win_o), int'(m_o_w));
        chk("bg_hit", int'(bg_o), int'(m_o_bg));
        chk("blink_phase", int'(ph_o), int'(phase_of(m_frames)));
`ifdef COLOR_ARB_COLLIDE_EN
        chk("collide", int'(collide_o), int'(m_col));
        chk("collide_mask", int'(mask_o), int'(m_mask));
`endif
    endtask

    // One clock: drive the inputs, advance the model at the edge, compare at the falling edge.
    task automatic step(input bit r, input bit f, input bit v, input logic [9:0] x,
                        input logic [3:0] rq, input logic [15:0] ix, input logic [3:0] bk);
        logic [3:0] e;
        bit ph;
        rst_n = r; fs = f; pv = v; dx = x; req = rq; idx = ix; blk = bk;
        @(posedge clk);
        if (!r) begin
            m_frames = 0; m_s1_v = 0; m_o_v = 0;
            m_s1_x = 0; m_s1_c = 0; m_s1_w = 0; m_s1_bg = 0;
            m_o_x = 0; m_o_c = 0; m_o_w = 0; m_o_bg = 0;
            m_acc = 0; m_mask = 0; m_col = 0;
        end else begin
            ph = phase_of(m_frames);
            e  = eligible(rq, ix, bk, ph);
            m_o_v = m_s1_v;
            if (m_s1_v) begin
                m_o_x = m_s1_x; m_o_c = m_s1_c; m_o_w = m_s1_w; m_o_bg = m_s1_bg;
            end
            m_s1_v = v; m_s1_x = x; m_s1_c = 4'd0; m_s1_w = 3'd0; m_s1_bg = 1;
            for (int i = 0; i < 4; i++) begin
                if (e[i]) begin
                    m_s1_c = ix[i*4 +: 4]; m_s1_w = 3'(i); m_s1_bg = 0;
                    break;
                end
            end
            if (v && e[0]) m_acc = m_acc | (e & 4'b1110);
            if (f) begin
                m_mask = m_acc; m_col = |m_acc; m_acc = 0;
                m_frames++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1, 0, 0, 10'd0, 4'd0, 16'd0, 4'd0);
    endtask

    initial begin
        rst_n = 0; fs = 0; pv = 0; dx = 0; req = 0; idx = 0; blk = 0;
        m_frames = 0; m_acc = 0; m_mask = 0; m_col = 0;
        m_s1_v = 0; m_o_v = 0;
        @(negedge clk);

        // Reset held for 3 cycles with busy inputs, then the first pixel appears 2 cycles later.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 10'd77, 4'hF, 16'h5678, 4'h0);
        chk("reset_valid", int'(pv_o), 0);
        chk("reset_color", int'(col_o), 0);
        step(1, 0, 1, 10'd100, 4'b0001, 16'h0009, 4'h0);
        chk("first_px_not_early", int'(pv_o), 0);
        idle();
        chk("first_px_valid", int'(pv_o), 1);
        chk("first_px_x", int'(dx_o), 100);
        chk("first_px_color", int'(col_o), 9);

        // Priority: layer 1 wins first; once its index is transparent, layer 2 wins.
        step(1, 0, 1, 10'd5, 4'b1110, {4'd3, 4'd2, 4'd5, 4'd7}, 4'h0);
        step(1, 0, 1, 10'd6, 4'b1110, {4'd3, 4'd2, 4'd0, 4'd7}, 4'h0);
        chk("prio_color_a", int'(col_o), 5);
        chk("prio_winner_a", int'(win_o), 1);
        idle();
        chk("prio_color_b", int'(col_o), 2);
        chk("prio_winner_b", int'(win_o), 2);
        idle();
        chk("hold_color", int'(col_o), 2);

        // Background line of 640 pixels.
        for (int i = 0; i < 640; i++) step(1, 0, 1, 10'(i), 4'd0, 16'h1234, 4'hF);
        idle(); idle();
        chk("bg_hit_end", int'(bg_o), 1);
        chk("bg_color_end", int'(col_o), 0);
        chk("bg_x_end", int'(dx_o), 639);

        // Blink: layer 0 blinks with layer 1 underneath; the phase flips every 2 frames.
        step(0, 0, 0, 10'd0, 4'd0, 16'd0, 4'd0);
        for (int f = 0; f < 6; f++) begin
            step(1, 0, 1, 10'(f * 10), 4'b0011, 16'h0021, 4'b0001);
            step(1, 1, 1, 10'(f * 10 + 1), 4'b0011, 16'h0021, 4'b0001);
            chk("blink_frame_px", int'(win_o), ((f / 2) % 2));
            step(1, 0, 1, 10'(f * 10 + 2), 4'b0011, 16'h0021, 4'b0001);
            chk("blink_pulse_px_old", int'(win_o), ((f / 2) % 2));
            idle();
            chk("blink_after_pulse", int'(win_o), (((f + 1) / 2) % 2));
        end
        chk("blink_phase_hidden", int'(ph_o), 1);

        // A one-cycle reset in the middle of a stream.
        step(1, 0, 1, 10'd300, 4'b0010, 16'h0030, 4'h0);
        step(1, 0, 1, 10'd301, 4'b0010, 16'h0030, 4'h0);
        step(0, 0, 1, 10'd302, 4'b0010, 16'h0030, 4'h0);
        chk("midreset_v0", int'(pv_o), 0);
        chk("midreset_phase", int'(ph_o), 0);
        step(1, 0, 1, 10'd500, 4'b0010, 16'h0030, 4'h0);
        chk("midreset_v1", int'(pv_o), 0);
        step(1, 0, 1, 10'd501, 4'b0010, 16'h0030, 4'h0);
        chk("midreset_v2", int'(pv_o), 1);
        chk("midreset_x", int'(dx_o), 500);

`ifdef COLOR_ARB_COLLIDE_EN
        // Collision: layers 0 and 2 overlap on one pixel in frame N.
        step(0, 0, 0, 10'd0, 4'd0, 16'd0, 4'd0);
        step(1, 0, 1, 10'd40, 4'b0101, {4'd0, 4'd3, 4'd0, 4'd4}, 4'h0);
        idle();
        step(1, 1, 0, 10'd0, 4'd0, 16'd0, 4'd0);
        chk("collide_set", int'(collide_o), 1);
        chk("collide_mask_set", int'(mask_o), 4);
        step(1, 0, 1, 10'd41, 4'b0001, 16'h0004, 4'h0);
        step(1, 1, 0, 10'd0, 4'd0, 16'd0, 4'd0);
        chk("collide_clear", int'(collide_o), 0);
        chk("collide_mask_clear", int'(mask_o), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
